// File: rtl/muldiv_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_sign_ctl.sv
// Operand sign handling: magnitudes and result-sign flags at accept time, plus the
// conditional two's-complement applied to the finished magnitude result.
module muldiv_sign_ctl
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  muldiv_op_e          op,
  input  logic [XLEN-1:0]     a,
  input  logic [XLEN-1:0]     b,
  input  logic [2*XLEN-1:0]   fix_in,
  input  logic                fix_neg,
  output logic [XLEN-1:0]     abs_a,
  output logic [XLEN-1:0]     abs_b,
  output logic                neg_q,
  output logic                neg_r,
  output logic                is_div,
  output logic                hi_sel,
  output logic [2*XLEN-1:0]   fix_out
);

  logic a_sgn, b_sgn, a_neg, b_neg;

  always_comb begin
    is_div = op[2];
    hi_sel = !op[2] && (op[1:0] != 2'b00);
    a_sgn  = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
             (op == OP_DIV) || (op == OP_REM);
    b_sgn  = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg  = a_sgn && a[XLEN-1];
    b_neg  = b_sgn && b[XLEN-1];
    abs_a  = a_neg ? -a : a;
    abs_b  = b_neg ? -b : b;
    // A zero divisor must yield an all-ones quotient regardless of the dividend sign.
    neg_q  = (a_neg ^ b_neg) && (!is_div || (b != '0));
    neg_r  = is_div && a_neg;
    fix_out = fix_neg ? -fix_in : fix_in;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide
// sharing one adder/subtractor, with valid/ready handshake on both sides.
//
// state | meaning
// IDLE  | ready to accept a new op
// CALC  | one iteration per cycle, counter XLEN-1 down to 0
// DONE  | result held with out_valid until out_ready
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit DIV_FAST = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  muldiv_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   hi_q, lo_q, opnd_q, result_q;
  logic              is_div_q, is_rem_q, hi_sel_q, res_neg_q, zero_q;

  logic [XLEN-1:0]   sc_abs_a, sc_abs_b;
  logic              sc_neg_q, sc_neg_r, sc_is_div, sc_hi_sel;
  logic [2*XLEN-1:0] fix_in, fix_out;

  logic [XLEN:0]     add_a, add_b;
  logic [XLEN+1:0]   sum_full;
  logic [XLEN:0]     sum;
  logic              sub, carry;
  logic [XLEN-1:0]   hi_nx, lo_nx, fin_val, fast_val;
  logic              accept, div0, ovf, fast;

  muldiv_sign_ctl #(.XLEN(XLEN)) u_sign (
    .op      (muldiv_op_e'(op)),
    .a       (a),
    .b       (b),
    .fix_in  (fix_in),
    .fix_neg (res_neg_q),
    .abs_a   (sc_abs_a),
    .abs_b   (sc_abs_b),
    .neg_q   (sc_neg_q),
    .neg_r   (sc_neg_r),
    .is_div  (sc_is_div),
    .hi_sel  (sc_hi_sel),
    .fix_out (fix_out)
  );

  always_comb begin
    div0     = (b == '0);
    ovf      = ((op == OP_DIV) || (op == OP_REM)) &&
               (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    fast     = DIV_FAST && op[2] && (div0 || ovf);
    fast_val = div0 ? (op[1] ? a : '1) : (op[1] ? '0 : a);
  end

  // Shared adder: multiply adds the multiplicand into the high half, divide
  // subtracts the divisor from the shifted partial remainder.
  always_comb begin
    sub   = is_div_q;
    add_a = is_div_q ? {hi_q, lo_q[XLEN-1]} : {1'b0, hi_q};
    add_b = (is_div_q || lo_q[0]) ? {1'b0, opnd_q} : '0;
    sum_full = {1'b0, add_a} + {1'b0, add_b ^ {(XLEN+1){sub}}} +
               {{(XLEN+1){1'b0}}, sub};
    carry = sum_full[XLEN+1];
    sum   = sum_full[XLEN:0];
    if (is_div_q) begin
      if (carry) begin
        hi_nx = sum[XLEN-1:0];
        lo_nx = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_nx = add_a[XLEN-1:0];
        lo_nx = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_nx = sum[XLEN:1];
      lo_nx = {sum[0], lo_q[XLEN-1:1]};
    end
    fix_in  = is_div_q ? {{XLEN{1'b0}}, (is_rem_q ? hi_nx : lo_nx)} : {hi_nx, lo_nx};
    fin_val = hi_sel_q ? fix_out[2*XLEN-1:XLEN] : fix_out[XLEN-1:0];
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: if (!flush && in_valid) begin
        accept  = 1'b1;
        state_d = fast ? DONE : CALC;
      end
      CALC: if (flush) state_d = IDLE;
            else if (cnt_q == '0) state_d = DONE;
      DONE: if (flush || out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      is_rem_q  <= 1'b0;
      hi_sel_q  <= 1'b0;
      res_neg_q <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (flush && (state_q != IDLE)) begin
        cnt_q    <= '0;
        result_q <= '0;
        zero_q   <= 1'b0;
      end else if (accept) begin
        cnt_q     <= CNT_LAST;
        hi_q      <= '0;
        opnd_q    <= sc_is_div ? sc_abs_b : sc_abs_a;
        lo_q      <= sc_is_div ? sc_abs_a : sc_abs_b;
        is_div_q  <= sc_is_div;
        is_rem_q  <= sc_is_div && op[1];
        hi_sel_q  <= sc_hi_sel;
        res_neg_q <= (sc_is_div && op[1]) ? sc_neg_r : sc_neg_q;
        if (fast) begin
          result_q <= fast_val;
          zero_q   <= (fast_val == '0);
        end
      end else if (state_q == CALC) begin
        hi_q <= hi_nx;
        lo_q <= lo_nx;
        if (cnt_q == '0) begin
          result_q <= fin_val;
          zero_q   <= (fin_val == '0);
        end else begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q && out_valid;

endmodule
